// File: rtl/systolic_tile_feeder_if.sv
// Host-side and array-side signals of the systolic tile feeder.
// The host drives the master end; the feeder takes the slave end.
interface systolic_tile_feeder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic             busy;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    input  out_last,
    input  busy
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    output out_last,
    output busy
  );
endinterface

// File: rtl/systolic_tile_feeder.sv
// Loads a DEPTH x WIDTH tile, then streams it diagonally skewed.
// Optional trailing zero drain: define TILE_FEEDER_FLUSH_EN.
module systolic_tile_feeder #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int FLUSH_LEN = 8
) (
  input  logic                clk,
  input  logic                rst,
  systolic_tile_feeder_if.slave bus
);

  localparam int WCW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW  = $clog2(DEPTH + WIDTH);
  localparam logic [WCW-1:0] W_LAST = WCW'(DEPTH - 1);
  localparam logic [TW-1:0]  T_LAST = TW'(DEPTH + WIDTH - 2);

`ifdef TILE_FEEDER_FLUSH_EN
  localparam int FCW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam logic [FCW-1:0] F_LAST = FCW'(FLUSH_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    FLUSH
  } state_e;
`else
  wire unused_flush_len = |FLUSH_LEN;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM
  } state_e;
`endif

  state_e           state_q, state_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [TW-1:0]    t_q, t_d;
  logic [WIDTH-1:0] tile_q [DEPTH];
  logic [WIDTH-1:0] tile_d [DEPTH];
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             in_ready;
  logic             xfer;
  int               idx;

`ifdef TILE_FEEDER_FLUSH_EN
  logic [FCW-1:0]   fcnt_q, fcnt_d;
`endif

  assign in_ready = ~rst &
                    ((state_q == IDLE) |
                     (state_q == LOAD));
  assign xfer     = bus.in_valid & in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign bus.busy      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    t_d     = t_q;
    tile_d  = tile_q;
`ifdef TILE_FEEDER_FLUSH_EN
    fcnt_d  = fcnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          tile_d[0] = bus.in_data;
          wcnt_d    = WCW'(1);
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (xfer) begin
          tile_d[wcnt_q] = bus.in_data;
          if (wcnt_q == W_LAST) begin
            wcnt_d  = '0;
            t_d     = '0;
            state_d = STREAM;
          end else begin
            wcnt_d = wcnt_q + WCW'(1);
          end
        end
      end
      STREAM: begin
        if (t_q == T_LAST) begin
          t_d = '0;
`ifdef TILE_FEEDER_FLUSH_EN
          fcnt_d  = '0;
          state_d = FLUSH;
`else
          state_d = IDLE;
`endif
        end else begin
          t_d = t_q + TW'(1);
        end
      end
`ifdef TILE_FEEDER_FLUSH_EN
      FLUSH: begin
        if (fcnt_q == F_LAST) begin
          fcnt_d  = '0;
          state_d = IDLE;
        end else begin
          fcnt_d = fcnt_q + FCW'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs are precomputed from next state so they register with it.
  always_comb begin
    out_d   = '0;
    valid_d = 1'b0;
    last_d  = 1'b0;
    idx     = 0;
    if (state_d == STREAM) begin
      valid_d = 1'b1;
`ifndef TILE_FEEDER_FLUSH_EN
      last_d  = (t_d == T_LAST);
`endif
      for (int j = 0; j < WIDTH; j++) begin
        idx = int'(t_d) - j;
        if (idx >= 0 && idx < DEPTH) begin
          out_d[j] = tile_d[idx[WCW-1:0]][j];
        end
      end
    end
`ifdef TILE_FEEDER_FLUSH_EN
    if (state_d == FLUSH) begin
      valid_d = 1'b1;
      last_d  = (fcnt_d == F_LAST);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      t_q     <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      t_q     <= t_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

`ifdef TILE_FEEDER_FLUSH_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    tile_q <= tile_d;
  end

endmodule
